// File: rtl/editor_campo_bcd_if.sv
// Bundle between the debouncers / RTC write sequencer and one BCD field editor.
// The editor sits on the slave side; the surrounding controller on the master side.
interface editor_campo_bcd_if;
    logic       incremento;
    logic       decremento;
    logic       confirmar;
    logic       carga;
    logic [7:0] dato_rtc;
    logic       wr_ack;
    logic [7:0] valor;
    logic       editando;
    logic       wr_req;
    logic [7:0] wr_dato;

    modport master (
        output incremento, decremento, confirmar, carga, dato_rtc, wr_ack,
        input  valor, editando, wr_req, wr_dato
    );

    modport slave (
        input  incremento, decremento, confirmar, carga, dato_rtc, wr_ack,
        output valor, editando, wr_req, wr_dato
    );
endinterface

// File: rtl/editor_campo_bcd.sv
// Two-digit BCD time-field editor: inc/dec with wrap between MIN_VAL and MAX_VAL,
// abandons the edit after TIMEOUT_CYC quiet cycles, and commits the value to the
// RTC write path over a held req/ack handshake.
module editor_campo_bcd #(
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 59,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic               clk,
    input logic               rst_n,
    editor_campo_bcd_if.slave bus
);

    localparam logic [7:0] BCD_MIN = {4'(MIN_VAL / 10), 4'(MIN_VAL % 10)};
    localparam logic [7:0] BCD_MAX = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};
    localparam logic [6:0] BIN_MIN = 7'(MIN_VAL);
    localparam logic [6:0] BIN_MAX = 7'(MAX_VAL);

    // Counter only has to reach TIMEOUT_CYC-1.
    localparam int             CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [7:0]    valor_q,    valor_d;
    logic [7:0]    shadow_q,   shadow_d;
    logic [7:0]    wr_dato_q,  wr_dato_d;
    logic          wr_req_q,   wr_req_d;
    logic          editando_q, editando_d;
    logic [CW-1:0] cnt_q,      cnt_d;

    logic step_en;
    logic step_up;

    // Clamp an RTC readback into the legal field range; bad BCD digits count as "too big".
    function automatic logic [7:0] sanitize(input logic [7:0] d);
        logic [6:0] bin;
        bin = 7'({3'b000, d[7:4]} * 7'd10) + {3'b000, d[3:0]};
        if (d[7:4] > 4'd9 || d[3:0] > 4'd9) return BCD_MAX;
        if (bin > BIN_MAX)                  return BCD_MAX;
        if (bin < BIN_MIN)                  return BCD_MIN;
        return d;
    endfunction

    // BCD +1 with wrap MAX -> MIN.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == BCD_MAX)     return BCD_MIN;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD -1 with wrap MIN -> MAX.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == BCD_MIN)     return BCD_MAX;
        if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Simultaneous inc and dec cancel: no step, no activity.
    assign step_en = bus.incremento ^ bus.decremento;
    assign step_up = bus.incremento;

    // Next-state and datapath decisions for the IDLE/EDIT/WRITE controller.
    always_comb begin
        state_d   = state_q;
        valor_d   = valor_q;
        shadow_d  = shadow_q;
        wr_dato_d = wr_dato_q;
        wr_req_d  = wr_req_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (step_en) begin
                    // A step wins over a load arriving in the same cycle.
                    valor_d = step_up ? bcd_inc(valor_q) : bcd_dec(valor_q);
                    state_d = ST_EDIT;
                end else if (bus.carga) begin
                    valor_d  = sanitize(bus.dato_rtc);
                    shadow_d = sanitize(bus.dato_rtc);
                end
            end

            ST_EDIT: begin
                if (bus.confirmar) begin
                    wr_dato_d = valor_q;
                    wr_req_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WRITE;
                end else if (step_en) begin
                    valor_d = step_up ? bcd_inc(valor_q) : bcd_dec(valor_q);
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    // Quiet too long: throw the edit away, restore last committed value.
                    valor_d = shadow_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WRITE: begin
                cnt_d = '0;
                if (bus.wr_ack) begin
                    wr_req_d = 1'b0;
                    shadow_d = wr_dato_q;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                wr_req_d = 1'b0;
                cnt_d    = '0;
            end
        endcase

        editando_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset also drops a pending wr_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valor_q    <= BCD_MIN;
            shadow_q   <= BCD_MIN;
            wr_dato_q  <= 8'h00;
            wr_req_q   <= 1'b0;
            editando_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valor_q    <= valor_d;
            shadow_q   <= shadow_d;
            wr_dato_q  <= wr_dato_d;
            wr_req_q   <= wr_req_d;
            editando_q <= editando_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.valor    = valor_q;
    assign bus.editando = editando_q;
    assign bus.wr_req   = wr_req_q;
    assign bus.wr_dato  = wr_dato_q;

endmodule

// File: tb/tb_editor_campo_bcd.sv
// Directed bench: a 0..59 field with an 8-cycle timeout driven from a vector
// table, plus hand sequences for timeout, async reset and a 1..12 field.
module tb_editor_campo_bcd;

    typedef struct packed {
        logic       inc;
        logic       dec;
        logic       conf;
        logic       carga;
        logic [7:0] dato;
        logic       ack;
    } in_t;

    typedef struct {
        in_t        i;
        logic [7:0] valor;
        logic       ed;
        logic       req;
        logic [7:0] wdato;
    } vec_t;

    logic clk;
    logic rst_n;
    in_t  in_a;
    in_t  in_b;
    int   total;
    int   bad;
    vec_t vecs[$];

    editor_campo_bcd_if ifa ();
    editor_campo_bcd_if ifb ();

    assign ifa.incremento = in_a.inc;
    assign ifa.decremento = in_a.dec;
    assign ifa.confirmar  = in_a.conf;
    assign ifa.carga      = in_a.carga;
    assign ifa.dato_rtc   = in_a.dato;
    assign ifa.wr_ack     = in_a.ack;
    assign ifb.incremento = in_b.inc;
    assign ifb.decremento = in_b.dec;
    assign ifb.confirmar  = in_b.conf;
    assign ifb.carga      = in_b.carga;
    assign ifb.dato_rtc   = in_b.dato;
    assign ifb.wr_ack     = in_b.ack;

    editor_campo_bcd #(.MIN_VAL(0), .MAX_VAL(59), .TIMEOUT_CYC(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    editor_campo_bcd #(.MIN_VAL(1), .MAX_VAL(12), .TIMEOUT_CYC(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic in_t mk(input logic inc, dec, conf, carga, input logic [7:0] dato,
                               input logic ack);
        in_t r;
        r.inc = inc; r.dec = dec; r.conf = conf; r.carga = carga; r.dato = dato; r.ack = ack;
        return r;
    endfunction

    task automatic add(input logic inc, dec, conf, carga, input logic [7:0] dato, input logic ack,
                       input logic [7:0] v, input logic ed, req, input logic [7:0] wd);
        vec_t t;
        t.i = mk(inc, dec, conf, carga, dato, ack);
        t.valor = v; t.ed = ed; t.req = req; t.wdato = wd;
        vecs.push_back(t);
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit to_b, input in_t v);
        @(negedge clk);
        in_a = to_b ? '0 : v;
        in_b = to_b ? v : '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        in_a  = '0;
        in_b  = '0;
        rst_n = 1'b0;

        //   inc dec cnf crg dato  ack   valor ed req wdato
        add(1'b0,1'b0,1'b0,1'b1,8'h42,1'b0, 8'h42,1'b0,1'b0,8'h00);
        add(1'b0,1'b0,1'b0,1'b1,8'h59,1'b0, 8'h59,1'b0,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 8'h00,1'b1,1'b0,8'h00);
        add(1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 8'h59,1'b1,1'b0,8'h00);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h59,1'b1,1'b1,8'h59);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h59,1'b0,1'b0,8'h59);
        add(1'b0,1'b0,1'b0,1'b1,8'h09,1'b0, 8'h09,1'b0,1'b0,8'h59);
        add(1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 8'h10,1'b1,1'b0,8'h59);
        add(1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 8'h09,1'b1,1'b0,8'h59);
        add(1'b1,1'b1,1'b0,1'b0,8'h00,1'b0, 8'h09,1'b1,1'b0,8'h59);
        add(1'b0,1'b0,1'b0,1'b1,8'h17,1'b0, 8'h09,1'b1,1'b0,8'h59);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h09,1'b1,1'b1,8'h09);
        add(1'b1,1'b0,1'b0,1'b1,8'h33,1'b0, 8'h09,1'b1,1'b1,8'h09);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b0, 8'h09,1'b1,1'b1,8'h09);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h09,1'b1,1'b1,8'h09);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h09,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h09,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h09,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b1,8'h7A,1'b0, 8'h59,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b1,8'h12,1'b0, 8'h12,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b1,8'h65,1'b0, 8'h59,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b1,8'h12,1'b0, 8'h12,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b1,8'h0F,1'b0, 8'h59,1'b0,1'b0,8'h09);
        add(1'b0,1'b0,1'b0,1'b1,8'h16,1'b0, 8'h16,1'b0,1'b0,8'h09);
        add(1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 8'h17,1'b1,1'b0,8'h09);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h17,1'b1,1'b1,8'h17);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h17,1'b0,1'b0,8'h17);
        add(1'b0,1'b0,1'b0,1'b1,8'h00,1'b0, 8'h00,1'b0,1'b0,8'h17);
        add(1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 8'h59,1'b1,1'b0,8'h17);
        add(1'b1,1'b0,1'b0,1'b1,8'h30,1'b0, 8'h00,1'b1,1'b0,8'h17);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h00,1'b1,1'b1,8'h00);
        add(1'b1,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h00,1'b0,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,1'b1,8'h45,1'b0, 8'h01,1'b1,1'b0,8'h00);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0, 8'h01,1'b1,1'b1,8'h01);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h01,1'b0,1'b0,8'h01);
        add(1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 8'h02,1'b1,1'b0,8'h01);
        add(1'b0,1'b0,1'b1,1'b0,8'h00,1'b1, 8'h02,1'b1,1'b1,8'h02);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b0, 8'h02,1'b1,1'b1,8'h02);
        add(1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 8'h02,1'b0,1'b0,8'h02);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst valor_a", ifa.valor, 8'h00);
        chk("rst req_a", {7'd0, ifa.wr_req}, 8'h00);
        chk("rst ed_a", {7'd0, ifa.editando}, 8'h00);
        chk("rst wdato_a", ifa.wr_dato, 8'h00);
        chk("rst valor_b", ifb.valor, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors on the 0..59 field
        foreach (vecs[k]) begin
            cyc(1'b0, vecs[k].i);
            chk($sformatf("v%0d valor", k), ifa.valor, vecs[k].valor);
            chk($sformatf("v%0d editando", k), {7'd0, ifa.editando}, {7'd0, vecs[k].ed});
            chk($sformatf("v%0d wr_req", k), {7'd0, ifa.wr_req}, {7'd0, vecs[k].req});
            chk($sformatf("v%0d wr_dato", k), ifa.wr_dato, vecs[k].wdato);
        end

        // Timeout: 7 quiet cycles keep the edit, the 8th discards it
        cyc(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0));
        cyc(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        chk("to start valor", ifa.valor, 8'h31);
        repeat (7) cyc(1'b0, '0);
        chk("to 7 valor", ifa.valor, 8'h31);
        chk("to 7 editando", {7'd0, ifa.editando}, 8'h01);
        cyc(1'b0, '0);
        chk("to 8 valor", ifa.valor, 8'h30);
        chk("to 8 editando", {7'd0, ifa.editando}, 8'h00);
        chk("to 8 wr_req", {7'd0, ifa.wr_req}, 8'h00);

        // Async reset while a write is pending
        cyc(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 1'b0));
        cyc(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        cyc(1'b0, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
        chk("pre-rst wr_req", {7'd0, ifa.wr_req}, 8'h01);
        chk("pre-rst wr_dato", ifa.wr_dato, 8'h26);
        @(negedge clk);
        in_a  = '0;
        rst_n = 1'b0;
        #1;
        chk("async wr_req", {7'd0, ifa.wr_req}, 8'h00);
        chk("async valor", ifa.valor, 8'h00);
        chk("async editando", {7'd0, ifa.editando}, 8'h00);
        chk("async wr_dato", ifa.wr_dato, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 1..12 field: clamp both ends, wrap both ways, timeout of 4
        cyc(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0));
        chk("b below min", ifb.valor, 8'h01);
        cyc(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0));
        chk("b above max", ifb.valor, 8'h12);
        cyc(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0));
        chk("b in range", ifb.valor, 8'h05);
        cyc(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0));
        cyc(1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        chk("b wrap up", ifb.valor, 8'h01);
        cyc(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
        chk("b wrap down", ifb.valor, 8'h12);
        cyc(1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
        chk("b dec", ifb.valor, 8'h11);
        repeat (3) cyc(1'b1, '0);
        chk("b to 3 editando", {7'd0, ifb.editando}, 8'h01);
        cyc(1'b1, '0);
        chk("b to 4 valor", ifb.valor, 8'h12);
        chk("b to 4 editando", {7'd0, ifb.editando}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
